t03_fetch_unit: RTL

Instruction fetch stage for the team 03 RV32I core. Owns the program counter, issues one instruction-memory read per instruction over a request/busy/ack handshake, and drives the instruction word and the `freezeInstr` select into the downstream instruction holder. The holder passes `instruction_in` through when `freezeInstr` is low and holds its last registered word when it is high. This block therefore lowers `freezeInstr` for exactly the one cycle in which a fresh word is present.

---
 rtl/t03_fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/t03_fetch_unit.sv
// t03_fetch_unit: RV32I fetch stage that owns the PC, runs the memory request/ack handshake and drives the instruction holder.
// Define T03_FETCH_TIMEOUT_EN to enable the ack timeout, request re-issue and sticky fetchTimeout flag.
module t03_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] pcNext,
    input  logic        pcLoad,
    input  logic        stall,
    input  logic        memBusy,
    input  logic        memAck,
    input  logic [31:0] memData,
    output logic        memReq,
    output logic [31:0] memAddr,
    output logic [31:0] instruction_in,
    output logic        freezeInstr,
    output logic [31:0] pc,
    output logic        instrValid,
    output logic        fetchTimeout
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        EXEC = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_pc;
    logic [31:0] w_pcNext;
    logic        r_firstExec;
    logic        w_ackTaken;
    logic        w_timeoutHit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
        $error("t03_fetch_unit: TIMEOUT_CYCLES must be in 1..255");
    end

    assign w_ackTaken = (r_state == WAIT) && memAck;

    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        case (r_state)
            BOOT: w_stateNext = REQ;
            REQ: begin
                if (!memBusy) begin
                    w_stateNext = WAIT;
                end
            end
            WAIT: begin
                if (memAck) begin
                    w_stateNext = EXEC;
                end else if (w_timeoutHit) begin
                    w_stateNext = REQ;
                end
            end
            EXEC: begin
                // stall wins over pcLoad; the target is only taken on the advance cycle
                if (!stall) begin
                    w_stateNext = REQ;
                    w_pcNext    = pcLoad ? {pcNext[31:2], 2'b00} : r_pc + 32'd4;
                end
            end
            default: w_stateNext = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= BOOT;
            r_pc        <= RESET_PC;
            r_firstExec <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_pc        <= w_pcNext;
            r_firstExec <= w_ackTaken;
        end
    end

`ifdef T03_FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_waitCnt;
    logic       r_timeout;

    assign w_timeoutHit = (r_state == WAIT) && !memAck && (r_waitCnt == TO_LAST);

    // Counter is zero on every entry to WAIT because it is held clear outside WAIT
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_waitCnt <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == WAIT) begin
                r_waitCnt <= r_waitCnt + 8'd1;
            end else begin
                r_waitCnt <= 8'd0;
            end
            if (w_timeoutHit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign fetchTimeout = r_timeout;
`else
    assign w_timeoutHit = 1'b0;
    assign fetchTimeout = 1'b0;
`endif

    assign memReq         = (r_state == REQ);
    assign memAddr        = r_pc;
    assign pc             = r_pc;
    assign instruction_in = memData;
    assign freezeInstr    = ~w_ackTaken;
    assign instrValid     = r_firstExec;

endmodule
